// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared constants for the control-bundle pipeline (counter width, E/M bundle bit map, default kill mask)
package ctrl_pipe_pkg;
  localparam int CNT_W = 16;
  localparam int PCSRC = 3;
  localparam int REGWRITE = 2;
  localparam int MEMTOREG = 1;
  localparam int MEMWRITE = 0;
  localparam logic [3:0] DEF_KILL_MASK = 4'b1101;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one register stage of the control chain with stall and per-stage bubble insertion
module ctrl_pipe_stage #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] KILL_MASK = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             feed_valid,
  input  logic [WIDTH-1:0] feed,
  output logic [WIDTH-1:0] bundle,
  output logic             valid
);
  // reset clears; flush bubbles (non-kill bits still advance when enabled); en advances; otherwise hold
  always_ff @(posedge clk)
    if (!reset) begin
      bundle <= '0;
      valid  <= 1'b0;
    end else if (flush) begin
      bundle <= (en ? feed : bundle) & ~KILL_MASK;
      valid  <= 1'b0;
    end else if (en) begin
      bundle <= feed_valid ? feed : feed & ~KILL_MASK;
      valid  <= feed_valid;
    end
endmodule

// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: DEPTH-stage control-bundle pipeline with stall, per-stage flush and optional perf counters (CTRL_PIPE_PERF_EN)
module ctrl_pipe_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] KILL_MASK = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DEPTH-1:0] flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid_out,
  output logic [DEPTH-1:0] stage_valid
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);
  logic [DEPTH:0][WIDTH-1:0] bus;
  logic [DEPTH:0]            vld;
  assign bus[0] = d;
  assign vld[0] = valid_in;
  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      ctrl_pipe_stage #(.WIDTH(WIDTH), .KILL_MASK(KILL_MASK)) u_stage (
        .clk(clk),
        .reset(reset),
        .en(en),
        .flush(flush[k]),
        .feed_valid(vld[k]),
        .feed(bus[k]),
        .bundle(bus[k+1]),
        .valid(vld[k+1])
      );
    end
  endgenerate
  assign stage_valid = vld[DEPTH:1];
  assign valid_out = vld[DEPTH];
  assign q = valid_out ? bus[DEPTH] : bus[DEPTH] & ~KILL_MASK;
`ifdef CTRL_PIPE_PERF_EN
  // count stalled edges and edges with an empty last stage, saturating at all-ones
  always_ff @(posedge clk)
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (!en) stall_cnt <= sat_inc(stall_cnt);
      if (!valid_out) bubble_cnt <= sat_inc(bubble_cnt);
    end
`endif
endmodule

// File: doc/ctrl_pipe_reg.md
CTRL_PIPE_REG -- requirements
Module: ctrl_pipe_reg

Interface
REQ-001 Parameter WIDTH, default 4, control-bundle width in bits (>=1).
REQ-002 Parameter DEPTH, default 1, number of chained stages (>=1).
REQ-003 Parameter KILL_MASK, default {WIDTH{1'b1}}, per-bit mask of side-effect bits cleared on flush.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 en  input  1  advance enable; 0 = stall, whole chain holds.
REQ-007 flush  input  DEPTH  per-stage bubble request; bit k targets stage k.
REQ-008 valid_in  input  1  incoming bundle is a real instruction.
REQ-009 d  input  WIDTH  incoming control bundle.
REQ-010 q  output  WIDTH  control bundle of last stage.
REQ-011 valid_out  output  1  last stage holds a real instruction.
REQ-012 stage_valid  output  DEPTH  valid bit of every stage, bit k = stage k.

Function
REQ-013 Stage k (0..DEPTH-1) SHALL hold a WIDTH-bit bundle plus one valid bit; stage 0 is fed from d/valid_in, stage k from stage k-1.
REQ-014 With en=1 and flush[k]=0, stage k SHALL load its feed value at the rising edge (latency DEPTH cycles from d to q).
REQ-015 With en=0 and flush[k]=0, stage k SHALL hold bundle and valid unchanged.
REQ-016 With flush[k]=1, stage k SHALL load a bubble regardless of en: valid=0, KILL_MASK bits=0, non-masked bits take the feed value if en=1, else hold.
REQ-017 flush on stage k SHALL NOT affect stages other than k in the same cycle; a bubble propagates only by normal advance.
REQ-018 Simultaneous flush[k] and en=0 SHALL bubble stage k while all other stages hold.
REQ-019 q SHALL equal last-stage bundle with KILL_MASK bits forced to 0 whenever valid_out=0.
REQ-020 valid_in=0 entering stage 0 SHALL be treated as a bubble (KILL_MASK bits cleared).
REQ-021 Outputs SHALL be purely registered (no combinational path from d/en/flush to q), except the REQ-019 masking by the registered valid.

Reset
REQ-022 While reset=0 at a rising edge, every stage SHALL clear to bundle 0 and valid 0, overriding en and flush.
REQ-023 Reset mid-operation SHALL discard all in-flight bundles; first post-reset load occurs on the first edge with reset=1 and en=1.
REQ-024 Reset values: q=0, valid_out=0, stage_valid=0, counters (if present)=0.

Configuration
REQ-025 Macro CTRL_PIPE_PERF_EN defined: ports stall_cnt (output, 16) and bubble_cnt (output, 16) SHALL exist.
REQ-026 stall_cnt SHALL increment on each edge with reset=1 and en=0; bubble_cnt on each edge with reset=1 and valid_out=0; both saturate at 16'hFFFF.
REQ-027 Macro undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package ctrl_pipe_pkg SHALL hold counter width constant (16) and bit-index constants for the E/M bundle (PCSRC=3, REGWRITE=2, MEMTOREG=1, MEMWRITE=0) plus default kill mask 4'b1101.
REQ-029 One sub-module ctrl_pipe_stage (single stage: en, flush, feed, kill mask) SHALL be instantiated DEPTH times via generate.

Verification
REQ-030 Reset: reset=0 two cycles with d=4'hF, en=1 -> q=0, valid_out=0, stage_valid=0.
REQ-031 Advance, DEPTH=3: d=4'hA, valid_in=1, en=1 at cycle 0 -> q=4'hA, valid_out=1 at cycle 3.
REQ-032 Stall: en=0 for 5 cycles mid-stream -> q and stage_valid unchanged; stall_cnt +5 when CTRL_PIPE_PERF_EN.
REQ-033 Flush during stall, KILL_MASK=4'b1101: stage 1 holds 4'hF, en=0, flush=3'b010 -> stage 1 becomes 4'h2, valid 0; stages 0,2 unchanged.
REQ-034 Saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF, no wrap.
REQ-035 Reset mid-stream: full pipe, reset=0 one cycle -> all stage_valid=0 next cycle; refill resumes DEPTH cycles after release.
